// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : light_sequencer
// Purpose  : Latches a one-hot lane grant and runs a timed
//            GREEN -> YELLOW -> ALL-RED cycle on four lane signal heads.
//            Every lane other than the granted one stays red throughout.
//            All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module light_sequencer #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] aslane,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } state_t;

  // Phase reload values; each phase lasts (reload + 1) cycles.
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [3:0]       cur;
  logic [CNT_W-1:0] cnt;

  logic       lane_any;
  logic       lane_onehot;
  logic [3:0] lane_minus1;

  // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
  assign lane_minus1 = aslane - 4'd1;
  assign lane_any    = (aslane != 4'b0000);
  assign lane_onehot = lane_any && ((aslane & lane_minus1) == 4'b0000);

  // Sequencer state, phase counter and registered lamp/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= 4'b0000;
      cnt    <= '0;
      green  <= 4'b0000;
      yellow <= 4'b0000;
      red    <= 4'b1111;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // done and err are single-cycle pulses by default.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (lane_onehot) begin
            cur    <= aslane;
            cnt    <= GREEN_LOAD;
            state  <= GREEN;
            green  <= aslane;
            yellow <= 4'b0000;
            red    <= ~aslane;
            busy   <= 1'b1;
          end else if (lane_any) begin
            // Multi-hot grant: flag it, keep cur and stay all-red.
            err <= 1'b1;
          end
        end
        GREEN: begin
          if (cnt == '0) begin
            cnt    <= YELLOW_LOAD;
            state  <= YELLOW;
            green  <= 4'b0000;
            yellow <= cur;
            red    <= ~cur;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        YELLOW: begin
          if (cnt == '0) begin
            cnt    <= ALLRED_LOAD;
            state  <= ALLRED;
            yellow <= 4'b0000;
            red    <= 4'b1111;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ALLRED: begin
          if (cnt == '0) begin
            state <= IDLE;
            cur   <= 4'b0000;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          cur    <= 4'b0000;
          cnt    <= '0;
          green  <= 4'b0000;
          yellow <= 4'b0000;
          red    <= 4'b1111;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/light_sequencer.md
# light_sequencer

Timed signal-head sequencer placed directly downstream of the lane-arbitration (mode A/B) stage. It accepts the one-hot lane grant `aslane`, latches it, and drives a fixed GREEN → YELLOW → ALL-RED cycle on the four lane signal heads. It then returns to idle to accept the next grant. Every other lane is held red for the whole cycle. All outputs are registered.

## Interface
Parameters:
- `GREEN_CYC`, 8: green duration in clock cycles; legal range 1..2^CNT_W-1
- `YELLOW_CYC`, 3: yellow duration in cycles; legal range 1..2^CNT_W-1
- `ALLRED_CYC`, 2: all-red clearance in cycles; legal range 1..2^CNT_W-1
- `CNT_W`, 8: phase counter width

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `aslane` input 4: lane grant from the arbitration stage. Bit 3 is the highest-priority lane. Only one-hot values are valid; 0000 means no request.
- `green` output 4: per-lane green lamp.
- `yellow` output 4: per-lane yellow lamp.
- `red` output 4: per-lane red lamp.
- `busy` output 1: high in GREEN, YELLOW and ALLRED.
- `done` output 1: one-cycle pulse on return to IDLE.
- `err` output 1: one-cycle pulse when a multi-hot `aslane` is sampled in IDLE.

## Operation
- States are IDLE, GREEN, YELLOW and ALLRED, using a 2-bit encoding.
- Internal registers are `cur[3:0]` (latched lane), `cnt[CNT_W-1:0]` (phase down-counter) and the state register.
- **Lamp invariant:** for every lane i, exactly one of `green[i]`, `yellow[i]` and `red[i]` is 1 in every cycle.
  - `green` and `yellow` are each either 0000 or equal to `cur`.
  - `red` is the complement of (`green | yellow`).
- **IDLE:**
  - `red`=1111, `green`=`yellow`=0000, `busy`=0.
  - `aslane` is sampled every cycle.
  - Exactly one bit set: `cur`←`aslane`, `cnt`←GREEN_CYC-1, go to GREEN.
  - 0000: stay in IDLE, no pulse.
  - Two or more bits set: stay in IDLE, `err`=1 for one cycle, `cur` unchanged.
- **GREEN:**
  - `green`=`cur`, `red`=~`cur`.
  - `cnt` decrements each cycle.
  - When `cnt`==0: `cnt`←YELLOW_CYC-1, go to YELLOW.
- **YELLOW:**
  - `yellow`=`cur`, `red`=~`cur`.
  - When `cnt`==0: `cnt`←ALLRED_CYC-1, go to ALLRED.
- **ALLRED:**
  - `red`=1111.
  - When `cnt`==0: go to IDLE with `done`=1 in the first IDLE cycle.
  - `cur` is cleared to 0000 on entry to IDLE.
- `aslane` is ignored outside IDLE. Changes to it mid-cycle, including to 0000, have no effect; the latched `cur` is always served to completion.
- `err` is never asserted outside IDLE.
- There is no wrap-around hazard: the counter is always reloaded before it is decremented past 0.

## Timing
- **Reset values** (applied on a `clk` edge with `rst`=1, regardless of state):
  - state = IDLE, `cur`=0000, `cnt`=0
  - `red`=1111, `green`=0000, `yellow`=0000
  - `busy`=0, `done`=0, `err`=0
- Reset mid-cycle (e.g. during GREEN) forces all-red on the next cycle with no yellow phase and no `done` pulse.
- **Latency:** a valid `aslane` sampled at edge k puts green on the outputs from cycle k+1.
- **Phase timing for one grant** (cycles after sampling edge k):
  - Green: cycles k+1 .. k+GREEN_CYC.
  - Yellow: the next YELLOW_CYC cycles.
  - All-red: the next ALLRED_CYC cycles.
  - The IDLE cycle carrying `done`=1 follows.
- `busy` is high for exactly GREEN_CYC+YELLOW_CYC+ALLRED_CYC cycles per grant.
- **Back-to-back grants:** the `done` cycle is an IDLE cycle and samples `aslane`. The minimum grant-to-grant period is therefore GREEN_CYC+YELLOW_CYC+ALLRED_CYC+1 cycles (14 with defaults).
- `err` is asserted in the same registered cycle as the sampling edge's response (k+1).
- With any phase parameter set to 1, that phase lasts exactly one cycle.

## Test plan
- **Reset state:** assert `rst` for 2 cycles → `red`=1111, `green`=`yellow`=0000, `busy`=`done`=`err`=0.
- **Single grant, defaults:** `aslane`=0100 sampled at k.
  - `green`=0100 / `red`=1011 for k+1..k+8.
  - `yellow`=0100 for k+9..k+11.
  - `red`=1111 for k+12..k+13.
  - `done`=1 at k+14 only.
- **Input change mid-cycle:** `aslane`=1000 at k, then 0001 from k+3 → green stays 1000 through k+8. The 0001 grant, if still present, is sampled at the `done` cycle, giving `green`=0001 from k+15.
- **Invalid inputs:** `aslane`=0110 in IDLE → `err`=1 for one cycle, state stays IDLE, `red`=1111. `aslane`=0000 → no `err`, no state change.
- **Mid-cycle reset:** `rst`=1 at k+5 of a grant → at k+6 `red`=1111, `busy`=0, no `done`. Then `aslane`=0010 gives `green`=0010 one cycle after sampling.
- **Minimum phase lengths:** GREEN_CYC=YELLOW_CYC=ALLRED_CYC=1 → phases last 1 cycle each, `done` at k+4, and the lamp invariant is checked every cycle.
